dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory target for riscv_cpu load/store port: accepts one request
//  (memop, mem_wen, mem_addr, memdata) per handshake, performs byte/half/word
//  access on an internal word-wide RAM after a fixed latency, returns
//  sign/zero-extended load data or write acknowledge. Sits beside cpu in top.
// PARAMETERS
//  DEPTH_WORDS  4096           RAM depth in 32-bit words (power of 2)
//  BASE_ADDR    32'h8000_0000  byte address mapped to word 0
//  LATENCY      2              cycles from accept to rsp_valid (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, ACTIVE-LOW
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept (high only in IDLE)
//  memop      in   3   RV funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  mem_wen    in   1   1 = store, 0 = load
//  mem_addr   in   32  byte address
//  memdata    in   32  store data, LSB-aligned (sb uses [7:0], sh [15:0])
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   initiator takes response
//  rsp_data   out  32  load result (0 for stores and errors)
//  rsp_err    out  1   misaligned, illegal memop or out-of-range address
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, req_ready=1, rsp_valid=0, rsp_data=0,
//   rsp_err=0, counter=0. RAM contents not reset. Reset mid-transaction
//   abandons it; a store not yet committed is never written.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. req_valid&req_ready at edge N latches all request
//    fields, loads counter=LATENCY-1, goes WAIT (RESP directly if LATENCY=1).
//   WAIT: req_ready=0; counter decrements each edge; at counter==0 edge ->
//    RESP. Store byte-lanes commit on this same edge; load data sampled here.
//   RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&rsp_ready;
//    that edge -> IDLE, rsp_valid=0. No new request accepted in RESP.
//  Latency: rsp_valid first high in cycle after edge N+LATENCY.
//  Decode: off=mem_addr-BASE_ADDR (32-bit wrap); in range iff
//   off < 4*DEPTH_WORDS; word index off[AW+1:2], AW=log2(DEPTH_WORDS).
//  Lanes: b/bu lane off[1:0]; h/hu lanes {off[1],0}..+1; w all four.
//  Errors (rsp_err=1, rsp_data=0, no RAM write): memop 011/110/111;
//   store memop 100/101; h/hu with off[0]=1; w with off[1:0]!=0;
//   out of range. Errors still take full LATENCY and handshake.
//  Loads: b/h sign-extend from bit 7/15 of selected lane; bu/hu zero-extend.
//  Stores: only enabled lanes written; others keep value; rsp_data=0.
//  Read-after-write to same word in back-to-back transactions returns new data.
//  Inputs ignored outside IDLE accept edge; req_ready never depends
//   combinationally on req_valid.
// TESTING
//  1 sw 0x8000_0010 <- 0xDEADBEEF, then lw same -> rsp_data 0xDEADBEEF, err 0,
//    rsp_valid exactly LATENCY cycles after each accept.
//  2 after (1): lb 0x8000_0013 -> 0xFFFFFFDE; lbu -> 0x000000DE;
//    lh 0x8000_0010 -> 0xFFFFBEEF; lhu 0x8000_0012 -> 0x0000DEAD.
//  3 sb 0x8000_0011 <- 0x12345677 then lw 0x8000_0010 -> 0xDEAD77EF.
//  4 lw 0x8000_0012, sh 0x8000_0011, lw 0x7FFF_FFFC, memop 011 -> each err=1,
//    rsp_data 0; follow-up lw 0x8000_0010 unchanged 0xDEAD77EF.
//  5 hold rsp_ready=0 10 cycles in RESP -> rsp_valid/rsp_data stable,
//    req_ready=0, second req_valid not accepted until handshake.
//  6 sw 0x8000_0020 <- 0x1, drop rst during WAIT -> outputs at reset
//    values immediately; lw 0x8000_0020 after release returns old content.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory target for the CPU load/store port: one request per handshake,
// byte/half/word access on a word-wide RAM after a fixed latency.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  memop,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] memdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    memop_q, memop_d;
  logic          wen_q, wen_d;
  logic [31:0]   off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept_c;
  logic          done_c;
  logic          is_b, is_h, is_w, illegal, in_range, err_c;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wlane, rword, ld_val;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  assign accept_c  = (state_q == S_IDLE) && req_valid && req_ready_q;
  assign done_c    = (state_q == S_WAIT) && (cnt_q == '0);
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Decode of the latched request: size, lanes, error and load extraction.
  always_comb begin
    is_b    = 1'b0;
    is_h    = 1'b0;
    is_w    = 1'b0;
    illegal = 1'b0;
    case (memop_q)
      3'b000, 3'b100: is_b = 1'b1;
      3'b001, 3'b101: is_h = 1'b1;
      3'b010:         is_w = 1'b1;
      default:        illegal = 1'b1;
    endcase
    in_range = ((off_q >> (AW + 2)) == 32'd0);
    err_c    = illegal || (wen_q && memop_q[2]) || (is_h && off_q[0]) ||
               (is_w && (off_q[1:0] != 2'b00)) || !in_range;
    widx     = off_q[AW+1:2];
    rword    = mem[widx];
    ld_b     = 8'(rword >> {off_q[1:0], 3'b000});
    ld_h     = off_q[1] ? rword[31:16] : rword[15:0];

    be     = 4'b0000;
    wlane  = wdata_q;
    ld_val = rword;
    if (is_b) begin
      be     = 4'(4'b0001 << off_q[1:0]);
      wlane  = {4{wdata_q[7:0]}};
      ld_val = memop_q[2] ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
    end else if (is_h) begin
      be     = off_q[1] ? 4'b1100 : 4'b0011;
      wlane  = {2{wdata_q[15:0]}};
      ld_val = memop_q[2] ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
    end else if (is_w) begin
      be = 4'b1111;
    end
  end

  // Request capture and latency counter.
  always_comb begin
    cnt_d   = cnt_q;
    memop_d = memop_q;
    wen_d   = wen_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    if (accept_c) begin
      cnt_d   = CW'(LATENCY - 1);
      memop_d = memop;
      wen_d   = mem_wen;
      off_d   = mem_addr - BASE_ADDR;
      wdata_d = memdata;
    end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c)  state_d = S_WAIT;
      S_WAIT:  if (done_c)    state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs; response is captured on the commit edge.
  always_comb begin
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: if (accept_c) req_ready_d = 1'b0;
      S_WAIT: if (done_c) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_c;
        rsp_data_d  = (err_c || wen_q) ? 32'h0 : ld_val;
      end
      S_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        rsp_data_d  = 32'h0;
        rsp_err_d   = 1'b0;
      end
      default: begin
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      memop_q     <= 3'b000;
      wen_q       <= 1'b0;
      off_q       <= 32'h0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      memop_q     <= memop_d;
      wen_q       <= wen_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Store commit; reset forces IDLE, so an abandoned store never lands.
  always_ff @(posedge clk) begin
    if (done_c && wen_q && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores, loads, errors, backpressure, reset.
module tb_dmem_responder;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  memop;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] memdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_responder #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (32'h8000_0000),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .memop    (memop),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .memdata  (memdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE; returns #1 after the accept edge with inputs scrambled.
  task automatic issue(input string tag, input logic w, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    mem_wen   = w;
    memop     = op;
    mem_addr  = a;
    memdata   = d;
    chk({tag, "_rdy_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_wen   = ~w;
    memop     = 3'b111;
    mem_addr  = a ^ 32'h0000_0004;
    memdata   = ~d;
    chk({tag, "_rdy_busy"}, 32'(req_ready), 32'd0);
  endtask

  // Wait for the response (bounded), checking latency and payload.
  task automatic collect(input string tag, input logic [31:0] ed, input logic ee);
    int cyc;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(LAT));
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ee);
    issue(tag, w, op, a, d);
    collect(tag, ed, ee);
    handshake(tag);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    mem_wen   = 1'b0;
    memop     = 3'b010;
    mem_addr  = 32'h0;
    memdata   = 32'h0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // word store then load
    txn("t1_sw", 1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn("t1_lw", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // sub-word loads with sign/zero extension
    txn("t2_lb",  1'b0, 3'b000, 32'h8000_0013, 32'h0, 32'hFFFF_FFDE, 1'b0);
    txn("t2_lbu", 1'b0, 3'b100, 32'h8000_0013, 32'h0, 32'h0000_00DE, 1'b0);
    txn("t2_lh",  1'b0, 3'b001, 32'h8000_0010, 32'h0, 32'hFFFF_BEEF, 1'b0);
    txn("t2_lhu", 1'b0, 3'b101, 32'h8000_0012, 32'h0, 32'h0000_DEAD, 1'b0);

    // byte store only touches its lane
    txn("t3_sb", 1'b1, 3'b000, 32'h8000_0011, 32'h1234_5677, 32'h0, 1'b0);
    txn("t3_lw", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_77EF, 1'b0);
    txn("t3_lh", 1'b0, 3'b001, 32'h8000_0010, 32'h0, 32'h0000_77EF, 1'b0);

    // errors: misaligned, out of range, illegal memop, unsigned store
    txn("t4_lw_mis",  1'b0, 3'b010, 32'h8000_0012, 32'h0, 32'h0, 1'b1);
    txn("t4_sh_mis",  1'b1, 3'b001, 32'h8000_0011, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("t4_lw_low",  1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);
    txn("t4_op011",   1'b0, 3'b011, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    txn("t4_sbu",     1'b1, 3'b100, 32'h8000_0010, 32'h0000_0000, 32'h0, 1'b1);
    txn("t4_lw_high", 1'b0, 3'b010, 32'h8000_4000, 32'h0, 32'h0, 1'b1);
    txn("t4_lw_chk",  1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_77EF, 1'b0);

    // last in-range word
    txn("t4_sw_top", 1'b1, 3'b010, 32'h8000_3FFC, 32'h0123_4567, 32'h0, 1'b0);
    txn("t4_lw_top", 1'b0, 3'b010, 32'h8000_3FFC, 32'h0, 32'h0123_4567, 1'b0);

    // backpressure: response held, second request waits
    issue("t5", 1'b0, 3'b010, 32'h8000_0010, 32'h0);
    collect("t5", 32'hDEAD_77EF, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    mem_wen   = 1'b0;
    memop     = 3'b100;
    mem_addr  = 32'h8000_0010;
    memdata   = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t5_hold_vld", 32'(rsp_valid), 32'd1);
      chk("t5_hold_data", rsp_data, 32'hDEAD_77EF);
      chk("t5_hold_rdy", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("t5_vld_drop", 32'(rsp_valid), 32'd0);
    chk("t5_rdy_back", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t5b_accepted", 32'(req_ready), 32'd0);
    collect("t5b", 32'h0000_00EF, 1'b0);
    handshake("t5b");

    // reset during WAIT abandons the store
    txn("t6_sw_old", 1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 1'b0);
    issue("t6_sw_new", 1'b1, 3'b010, 32'h8000_0020, 32'h0000_0001);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_rdy", 32'(req_ready), 32'd1);
    chk("t6_rst_vld", 32'(rsp_valid), 32'd0);
    chk("t6_rst_data", rsp_data, 32'h0);
    chk("t6_rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    txn("t6_lw", 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
